// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default geometry, VC index width helper and flit record.
package noc_pkg;

   localparam int NUM_VC_DEF     = 4;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int PORT_NUM_DEF   = 5;

   // Width of a binary VC index; never narrower than one bit.
   function automatic int vch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] data;
      logic [PORT_NUM_DEF-1:0]   port;
      logic                      tail;
   } flit_t;

endpackage

// File: rtl/vc_arbmux_rr_arbiter.sv
// Packet-locking VC arbiter: holds the owner while locked, otherwise fixed-priority
// or round-robin search starting at ptr.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter  int N       = NUM_VC_DEF,
   parameter  bit RR_MODE = 1'b1,
   localparam int W       = vch_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   input  logic         lock_i,
   input  logic [W-1:0] owner_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      if (lock_i) begin
         // A locked owner without a flit yields a bubble rather than letting another VC interleave.
         if (req_i[owner_i]) begin
            gnt_o[owner_i] = 1'b1;
            idx_o          = owner_i;
         end
      end else if (RR_MODE) begin
         for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % N]) begin
               found                          = 1'b1;
               gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
               idx_o                          = W'((int'(ptr_i) + k) % N);
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!found && req_i[k]) begin
               found    = 1'b1;
               gnt_o[k] = 1'b1;
               idx_o    = W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/vc_arbmux.sv
// Router input-port VC arbiter/mux: packet-locked grant feeding a registered
// valid/ready output stage toward the crossbar.
module vc_arbmux
   import noc_pkg::*;
#(
   parameter  int NUM_VC     = NUM_VC_DEF,
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int PORT_NUM   = PORT_NUM_DEF,
   parameter  bit RR_MODE    = 1'b1,
   localparam int VCH_W      = vch_w(NUM_VC)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_VC-1:0]            req,
   input  logic [NUM_VC-1:0]            tail,
   input  logic [NUM_VC*DATA_WIDTH-1:0] idata,
   input  logic [NUM_VC*PORT_NUM-1:0]   iport,
   output logic [NUM_VC-1:0]            vcsel,
   output logic [NUM_VC-1:0]            pop,
   output logic                         ovalid,
   input  logic                         oready,
   output logic [DATA_WIDTH-1:0]        odata,
   output logic [VCH_W-1:0]             ovch,
   output logic [PORT_NUM-1:0]          oport,
   output logic                         otail,
   output logic                         req_any
);

   logic                  lock_q,   lock_d;
   logic [VCH_W-1:0]      owner_q,  owner_d;
   logic [VCH_W-1:0]      ptr_q,    ptr_d;
   logic                  ovalid_q, ovalid_d;
   logic [DATA_WIDTH-1:0] odata_q,  odata_d;
   logic [VCH_W-1:0]      ovch_q,   ovch_d;
   logic [PORT_NUM-1:0]   oport_q,  oport_d;
   logic                  otail_q,  otail_d;

   logic [NUM_VC-1:0]     gnt;
   logic [VCH_W-1:0]      sel;
   logic                  space;
   logic                  fire;

   rr_arbiter #(
      .N       (NUM_VC),
      .RR_MODE (RR_MODE)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .lock_i  (lock_q),
      .owner_i (owner_q),
      .gnt_o   (gnt),
      .idx_o   (sel)
   );

   // Grant is forced off during reset so upstream buffers never see a pop then.
   assign vcsel   = reset ? gnt : '0;
   assign space   = !ovalid_q || oready;
   assign fire    = (|vcsel) && space;
   assign pop     = vcsel & {NUM_VC{fire}};
   assign req_any = |req;

   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      ovalid_d = ovalid_q && !oready;
      odata_d  = odata_q;
      ovch_d   = ovch_q;
      oport_d  = oport_q;
      otail_d  = otail_q;
      if (fire) begin
         ovalid_d = 1'b1;
         odata_d  = idata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
         oport_d  = iport[int'(sel)*PORT_NUM +: PORT_NUM];
         otail_d  = tail[sel];
         ovch_d   = sel;
         if (tail[sel]) begin
            lock_d = 1'b0;
            // The round-robin pointer only advances once a whole packet has gone.
            if (RR_MODE) begin
               ptr_d = (int'(sel) == NUM_VC - 1) ? '0 : sel + VCH_W'(1);
            end
         end else begin
            lock_d  = 1'b1;
            owner_d = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_q   <= 1'b0;
         owner_q  <= '0;
         ptr_q    <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         ovch_q   <= '0;
         oport_q  <= '0;
         otail_q  <= 1'b0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
         ovch_q   <= ovch_d;
         oport_q  <= oport_d;
         otail_q  <= otail_d;
      end
   end

   assign ovalid = ovalid_q;
   assign odata  = odata_q;
   assign ovch   = ovch_q;
   assign oport  = oport_q;
   assign otail  = otail_q;

endmodule

// File: tb/tb_vc_arbmux.sv
// Directed bench for vc_arbmux: round-robin instance driven from a vector table,
// plus hand sequences for reset, owner bubble and fixed priority.
module tb_vc_arbmux;

   localparam int NV = 4;
   localparam int DW = 32;
   localparam int PN = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [NV-1:0]   req, tail;
   logic [NV*DW-1:0] idata;
   logic [NV*PN-1:0] iport;
   logic            oready;

   logic [NV-1:0] vcsel_r, pop_r, vcsel_f, pop_f;
   logic          ovalid_r, otail_r, reqany_r, ovalid_f, otail_f, reqany_f;
   logic [DW-1:0] odata_r, odata_f;
   logic [1:0]    ovch_r, ovch_f;
   logic [PN-1:0] oport_r, oport_f;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vc_arbmux #(.NUM_VC(NV), .DATA_WIDTH(DW), .PORT_NUM(PN), .RR_MODE(1'b1)) dut_rr (
      .clk(clk), .reset(reset), .req(req), .tail(tail), .idata(idata), .iport(iport),
      .vcsel(vcsel_r), .pop(pop_r), .ovalid(ovalid_r), .oready(oready), .odata(odata_r),
      .ovch(ovch_r), .oport(oport_r), .otail(otail_r), .req_any(reqany_r)
   );

   vc_arbmux #(.NUM_VC(NV), .DATA_WIDTH(DW), .PORT_NUM(PN), .RR_MODE(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .req(req), .tail(tail), .idata(idata), .iport(iport),
      .vcsel(vcsel_f), .pop(pop_f), .ovalid(ovalid_f), .oready(oready), .odata(odata_f),
      .ovch(ovch_f), .oport(oport_f), .otail(otail_f), .req_any(reqany_f)
   );

   typedef struct {
      logic [NV-1:0] req;
      logic [NV-1:0] tail;
      logic          ordy;
      logic [NV-1:0] evsel;
      logic [NV-1:0] epop;
      logic          eov;
      logic [1:0]    ech;
      logic [DW-1:0] edat;
      logic [PN-1:0] eport;
      logic          etl;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] r, input logic [3:0] t, input logic o,
                      input logic [3:0] vs, input logic [3:0] pp, input logic ov,
                      input logic [1:0] ch, input logic [31:0] d, input logic [4:0] pt,
                      input logic tl);
      vec_t v;
      v.req = r; v.tail = t; v.ordy = o; v.evsel = vs; v.epop = pp; v.eov = ov;
      v.ech = ch; v.edat = d; v.eport = pt; v.etl = tl;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic o);
      req = r; tail = t; oready = o;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NV; i++) begin
         idata[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
         iport[i*PN +: PN] = PN'(1 << i);
      end

      // round-robin fairness: single-flit packets from all VCs
      add(4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 0, 0, 32'h0,          5'b00000, 0);
      add(4'b1111, 4'b1111, 1, 4'b0010, 4'b0010, 1, 0, 32'hA5A5_0000, 5'b00001, 1);
      add(4'b1111, 4'b1111, 1, 4'b0100, 4'b0100, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b1111, 4'b1111, 1, 4'b1000, 4'b1000, 1, 2, 32'hA5A5_0002, 5'b00100, 1);
      add(4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 1, 3, 32'hA5A5_0003, 5'b01000, 1);
      add(4'b1111, 4'b1111, 1, 4'b0010, 4'b0010, 1, 0, 32'hA5A5_0000, 5'b00001, 1);
      add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 1, 32'hA5A5_0001, 5'b00010, 1);
      // packet lock: VC2 3-flit packet while VC0 keeps requesting
      add(4'b0101, 4'b0000, 1, 4'b0100, 4'b0100, 0, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0101, 4'b0000, 1, 4'b0100, 4'b0100, 1, 2, 32'hA5A5_0002, 5'b00100, 0);
      add(4'b0101, 4'b0100, 1, 4'b0100, 4'b0100, 1, 2, 32'hA5A5_0002, 5'b00100, 0);
      add(4'b0001, 4'b0001, 1, 4'b0001, 4'b0001, 1, 2, 32'hA5A5_0002, 5'b00100, 1);
      add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 32'hA5A5_0000, 5'b00001, 1);
      // backpressure holding a VC1 flit for three cycles
      add(4'b0010, 4'b0010, 1, 4'b0010, 4'b0010, 0, 0, 32'hA5A5_0000, 5'b00001, 1);
      add(4'b0011, 4'b0011, 0, 4'b0001, 4'b0000, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0011, 4'b0011, 0, 4'b0001, 4'b0000, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0011, 4'b0011, 0, 4'b0001, 4'b0000, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0011, 4'b0011, 1, 4'b0001, 4'b0001, 1, 1, 32'hA5A5_0001, 5'b00010, 1);
      add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 32'hA5A5_0000, 5'b00001, 1);

      // reset held with every VC requesting
      reset = 1'b0;
      drive(4'b1111, 4'b1111, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_vcsel",  vcsel_r,  4'b0000);
      chk("rst_pop",    pop_r,    4'b0000);
      chk("rst_ovalid", ovalid_r, 1'b0);
      chk("rst_odata",  odata_r,  32'h0);
      chk("rst_ovch",   ovch_r,   2'd0);
      chk("rst_fp_vcsel", vcsel_f, 4'b0000);
      next_cycle();
      reset = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].req, vq[i].tail, vq[i].ordy);
         @(negedge clk);
         chk($sformatf("v%0d_vcsel",  i), vcsel_r,  vq[i].evsel);
         chk($sformatf("v%0d_pop",    i), pop_r,    vq[i].epop);
         chk($sformatf("v%0d_ovalid", i), ovalid_r, vq[i].eov);
         chk($sformatf("v%0d_ovch",   i), ovch_r,   vq[i].ech);
         chk($sformatf("v%0d_odata",  i), odata_r,  vq[i].edat);
         chk($sformatf("v%0d_oport",  i), oport_r,  vq[i].eport);
         chk($sformatf("v%0d_otail",  i), otail_r,  vq[i].etl);
         chk($sformatf("v%0d_reqany", i), reqany_r, |vq[i].req);
         next_cycle();
      end

      // owner bubble: VC1 starts a packet, drops req for 2 cycles while VC0 waits
      drive(4'b0010, 4'b0000, 1'b1);
      @(negedge clk);
      chk("bub_start_vcsel", vcsel_r, 4'b0010);
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         drive(4'b0001, 4'b0001, 1'b1);
         @(negedge clk);
         chk($sformatf("bub%0d_vcsel", k), vcsel_r, 4'b0000);
         chk($sformatf("bub%0d_pop", k),   pop_r,   4'b0000);
         next_cycle();
      end
      drive(4'b0011, 4'b0010, 1'b1);
      @(negedge clk);
      chk("bub_resume_pop", pop_r, 4'b0010);
      next_cycle();
      drive(4'b0001, 4'b0001, 1'b1);
      @(negedge clk);
      chk("bub_after_vcsel", vcsel_r, 4'b0001);
      chk("bub_after_ovch",  ovch_r,  2'd1);
      chk("bub_after_otail", otail_r, 1'b1);
      next_cycle();

      // reset mid-packet clears the lock and drops the output flit
      drive(4'b0010, 4'b0000, 1'b1);
      @(negedge clk);
      chk("mid_lock_vcsel", vcsel_r, 4'b0010);
      next_cycle();
      reset = 1'b0;
      drive(4'b0001, 4'b0001, 1'b1);
      @(negedge clk);
      chk("mid_rst_vcsel", vcsel_r, 4'b0000);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("mid_post_ovalid", ovalid_r, 1'b0);
      chk("mid_post_vcsel",  vcsel_r,  4'b0001);
      next_cycle();

      // fixed priority: VC1 always beats VC3
      for (int k = 0; k < 4; k++) begin
         drive(4'b1010, 4'b1010, 1'b1);
         @(negedge clk);
         chk($sformatf("fp%0d_vcsel", k), vcsel_f, 4'b0010);
         chk($sformatf("fp%0d_pop", k),   pop_f,   4'b0010);
         if (k > 0) begin
            chk($sformatf("fp%0d_ovch", k),  ovch_f,  2'd1);
            chk($sformatf("fp%0d_odata", k), odata_f, 32'hA5A5_0001);
         end
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vc_arbmux.md
# vc_arbmux

Parametrised virtual-channel arbiter and multiplexer for a router input port. It selects one of NUM_VC input virtual channels each cycle and locks the selection for the length of a packet, until its tail flit. The winning flit goes into a registered output stage toward the crossbar, with valid/ready backpressure. It sits between the per-VC input buffers and the crossbar, and supports fixed-priority or round-robin arbitration.

## Interface
- NUM_VC, 4, number of virtual channels (≥2)
- DATA_WIDTH, 32, flit width
- PORT_NUM, 5, width of one-hot output-port request
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- req  input  NUM_VC  VC i holds a flit at its buffer head
- tail  input  NUM_VC  head flit of VC i is the last flit of its packet
- idata  input  NUM_VC*DATA_WIDTH  head flits, VC i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- iport  input  NUM_VC*PORT_NUM  routed output port per VC, same packing
- vcsel  output  NUM_VC  one-hot combinational grant, zero or one bit set
- pop  output  NUM_VC  one-hot dequeue strobe, equal to vcsel & {NUM_VC{fire}}
- ovalid  output  1  registered flit valid toward crossbar
- oready  input  1  crossbar accepts the output flit this cycle
- odata  output  DATA_WIDTH  registered flit
- ovch  output  VCH_W  binary index of the source VC, VCH_W = max(1, clog2(NUM_VC))
- oport  output  PORT_NUM  registered output-port request
- otail  output  1  registered tail marker
- req_any  output  1  OR of req

## Operation
- State: lock (1 bit), owner (VCH_W bits), ptr (VCH_W bits, round-robin start), plus the output register.
- Grant:
  - lock = 1: vcsel = onehot(owner) if req[owner], else 0. A bubble is inserted and the lock is kept; no other VC may interleave.
  - lock = 0, RR_MODE = 0: lowest-index requesting VC.
  - lock = 0, RR_MODE = 1: first requesting VC searching ptr, ptr+1, … with wrap modulo NUM_VC.
- space = !ovalid | oready; fire = |vcsel & space; sel = index of vcsel.
- On fire:
  - Output load: odata/oport/otail ← idata/iport/tail of sel; ovch ← sel; ovalid ← 1.
  - tail[sel] = 0: lock ← 1, owner ← sel.
  - tail[sel] = 1: lock ← 0, and ptr ← (sel+1) mod NUM_VC when RR_MODE = 1.
- If no fire and ovalid & oready: ovalid ← 0, and data registers hold.
- A single-flit packet (tail = 1 on its first flit) never sets lock.
- ptr changes only at packet completion, never on body flits.
- In RR_MODE = 0, ptr is unused and stays 0.

## Timing
- Reset values (reset = 0 at a clk edge): ovalid 0, odata 0, ovch 0, oport 0, otail 0, lock 0, owner 0, ptr 0.
- vcsel and pop are combinational, so they are 0 while reset is low regardless of req.
- Latency: a flit popped in cycle n is presented on ovalid/odata in cycle n+1.
- Throughput: one flit per cycle while oready = 1.
- Backpressure: ovalid = 1 with oready = 0 forces space = 0, so pop = 0 and all outputs hold stable. Arbitration state (lock, owner, ptr) is unchanged.
- Simultaneous events: an output flit leaving (oready) and a new flit firing in the same cycle loads the new flit, and ovalid stays 1.
- Reset mid-packet: lock is cleared and any in-flight output flit is dropped. Upstream buffers must also be reset.

## Structure
- Shared package noc_pkg holds:
  - DATA_WIDTH, PORT_NUM and NUM_VC defaults
  - a clog2-based VCH_W helper function
  - a flit struct of data, port and tail
- One sub-module, rr_arbiter (parameters N and RR_MODE). Inputs: req, ptr, lock, owner. Outputs: one-hot grant and its binary index.
- vc_arbmux owns the lock/ptr registers and the output stage.

## Test plan
- Reset: assert reset = 0 with req = 4'b1111 → vcsel = 0, pop = 0, ovalid = 0, odata = 0. After release, vcsel = 4'b0001.
- Packet lock, RR_MODE = 1:
  - Stimulus: VC2 sends a 3-flit packet (tail on the 3rd); VC0 requests continuously from cycle 1.
  - Expected: vcsel = 4'b0100 for 3 consecutive fires, ovch = 2 on 3 consecutive output cycles; then VC0 wins and ptr = 3.
- Round-robin fairness: all four VCs send single-flit packets continuously with oready = 1 → ovch sequence 0,1,2,3,0,1 and one flit per cycle.
- Fixed priority, RR_MODE = 0: req = 4'b1010 single-flit packets → VC1 always wins; VC3 is starved while req[1] = 1.
- Backpressure: oready = 0 for 3 cycles with ovalid = 1, odata = 32'hA5A5_0001 → odata, ovch and oport stable, pop = 0. When oready returns to 1, the next flit appears the following cycle.
- Owner bubble: mid-packet owner VC1 drops req for 2 cycles while VC0 requests → vcsel = 0 for 2 cycles, no pop of VC0. VC1 resumes and completes.
